capture_ctrl: RTL and testbench

Capture controller sitting directly downstream of the byte-packing cache stage in the logic-analyzer datapath. It writes each packed sample word into a circular sample memory while armed. On trigger it records a programmable number of post-trigger words, then stops. It then streams the most recent N words out to the transmitter through a ready/strobe handshake.

---
 rtl/logip_pkg.sv | 15 +
 rtl/capture_ctrl_if.sv | 29 ++
 rtl/capture_ctrl_sdp_ram.sv | 30 +++
 rtl/capture_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_capture_ctrl.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/logip_pkg.sv
// Shared definitions for the logic-analyzer capture path: controller states
// and the width of the configuration counters.
package logip_pkg;

  localparam int CFG_CNT_W = 16;

  typedef enum logic [2:0] {
    CAP_IDLE   = 3'd0,
    CAP_ARMED  = 3'd1,
    CAP_DELAY  = 3'd2,
    CAP_RD_REQ = 3'd3,
    CAP_RD_OUT = 3'd4
  } capture_states_t;

endpackage

// File: rtl/capture_ctrl_if.sv
// Sample-stream bundle: packed words in from the cache stage, readout words
// out to the transmitter with a ready/strobe handshake.
interface capture_ctrl_if #(
  parameter int WIDTH = 4
);

  logic                 stb_i;
  logic [WIDTH*8-1:0]   d_i;
  logic                 rdy_i;
  logic                 stb_o;
  logic [WIDTH*8-1:0]   q_o;

  modport master (
    output stb_i,
    output d_i,
    output rdy_i,
    input  stb_o,
    input  q_o
  );

  modport slave (
    input  stb_i,
    input  d_i,
    input  rdy_i,
    output stb_o,
    output q_o
  );

endinterface

// File: rtl/capture_ctrl_sdp_ram.sv
// Simple dual-port synchronous RAM: one write port, one read port with a
// registered output (1-cycle latency). Contents and output are not reset.
module sdp_ram #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH),
  localparam int DW = WIDTH * 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Storage write and registered read
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/capture_ctrl.sv
// Capture controller: circular capture while armed, post-trigger delay, then
// readout of the most recent words. Build option CAPTURE_CTRL_NEWEST_FIRST_EN
// selects newest-first readout; otherwise oldest-first.
module capture_ctrl
  import logip_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_stb_i,
  input  logic [CFG_CNT_W-1:0] cfg_read_i,
  input  logic [CFG_CNT_W-1:0] cfg_delay_i,
  input  logic                 arm_i,
  input  logic                 trg_i,
  capture_ctrl_if.slave        bus,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = WIDTH * 8;

  localparam logic [2:0] ST_IDLE   = CAP_IDLE;
  localparam logic [2:0] ST_ARMED  = CAP_ARMED;
  localparam logic [2:0] ST_DELAY  = CAP_DELAY;
  localparam logic [2:0] ST_RD_REQ = CAP_RD_REQ;
  localparam logic [2:0] ST_RD_OUT = CAP_RD_OUT;

  localparam logic [CFG_CNT_W-1:0] RD_MAX  = CFG_CNT_W'(DEPTH - 1);
  localparam logic [CFG_CNT_W-1:0] CNT_ONE = CFG_CNT_W'(1'b1);
  localparam logic [CFG_CNT_W-1:0] CNT_ZERO = {CFG_CNT_W{1'b0}};
  localparam logic [AW-1:0]        PTR_ONE = AW'(1'b1);

  logic [2:0]           state_q,     state_d;
  logic [AW-1:0]        wr_ptr_q,    wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q,    rd_ptr_d;
  logic [CFG_CNT_W-1:0] rd_cnt_q,    rd_cnt_d;
  logic [CFG_CNT_W-1:0] dly_cnt_q,   dly_cnt_d;
  logic [CFG_CNT_W-1:0] cfg_read_q,  cfg_read_d;
  logic [CFG_CNT_W-1:0] cfg_delay_q, cfg_delay_d;
  logic                 stb_q,       stb_d;
  logic                 busy_q,      busy_d;
  logic                 done_q,      done_d;

  logic                 we_s;
  logic                 xfer_s;
  logic                 start_rd_s;
  logic [CFG_CNT_W-1:0] rd_clamp_s;
  logic [DW-1:0]        ram_q_s;

  assign xfer_s     = stb_q & bus.rdy_i;
  assign rd_clamp_s = (cfg_read_q > RD_MAX) ? RD_MAX : cfg_read_q;

  // Next-state logic for the capture/readout sequence
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rd_cnt_d    = rd_cnt_q;
    dly_cnt_d   = dly_cnt_q;
    cfg_read_d  = cfg_read_q;
    cfg_delay_d = cfg_delay_q;
    done_d      = 1'b0;
    we_s        = 1'b0;
    start_rd_s  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cfg_stb_i) begin
          cfg_read_d  = cfg_read_i;
          cfg_delay_d = cfg_delay_i;
        end else begin
          cfg_read_d  = cfg_read_q;
          cfg_delay_d = cfg_delay_q;
        end
        if (arm_i) begin
          state_d = ST_ARMED;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ARMED: begin
        we_s = bus.stb_i;
        if (bus.stb_i) begin
          wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
          wr_ptr_d = wr_ptr_q;
        end
        if (trg_i && (cfg_delay_q == CNT_ZERO)) begin
          state_d    = ST_RD_REQ;
          start_rd_s = 1'b1;
        end else if (trg_i) begin
          state_d   = ST_DELAY;
          dly_cnt_d = cfg_delay_q;
        end else begin
          state_d = ST_ARMED;
        end
      end

      ST_DELAY: begin
        we_s = bus.stb_i;
        if (bus.stb_i) begin
          wr_ptr_d  = wr_ptr_q + PTR_ONE;
          dly_cnt_d = dly_cnt_q - CNT_ONE;
          if (dly_cnt_q == CNT_ONE) begin
            state_d    = ST_RD_REQ;
            start_rd_s = 1'b1;
          end else begin
            state_d = ST_DELAY;
          end
        end else begin
          state_d = ST_DELAY;
        end
      end

      ST_RD_REQ: begin
        state_d = ST_RD_OUT;
      end

      ST_RD_OUT: begin
        if (xfer_s && (rd_cnt_q == CNT_ZERO)) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (xfer_s) begin
          rd_cnt_d = rd_cnt_q - CNT_ONE;
`ifdef CAPTURE_CTRL_NEWEST_FIRST_EN
          rd_ptr_d = rd_ptr_q - PTR_ONE;
`else
          rd_ptr_d = rd_ptr_q + PTR_ONE;
`endif
          state_d  = ST_RD_REQ;
        end else begin
          state_d = ST_RD_OUT;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Readout window is anchored on the pointer after the final capture write
    if (start_rd_s) begin
      rd_cnt_d = rd_clamp_s;
`ifdef CAPTURE_CTRL_NEWEST_FIRST_EN
      rd_ptr_d = wr_ptr_d - PTR_ONE;
`else
      rd_ptr_d = wr_ptr_d - PTR_ONE - rd_clamp_s[AW-1:0];
`endif
    end else begin
      rd_cnt_d = rd_cnt_d;
      rd_ptr_d = rd_ptr_d;
    end

    stb_d  = (state_d == ST_RD_OUT);
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      rd_cnt_q    <= CNT_ZERO;
      dly_cnt_q   <= CNT_ZERO;
      cfg_read_q  <= CNT_ZERO;
      cfg_delay_q <= CNT_ZERO;
      stb_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_cnt_q    <= rd_cnt_d;
      dly_cnt_q   <= dly_cnt_d;
      cfg_read_q  <= cfg_read_d;
      cfg_delay_q <= cfg_delay_d;
      stb_q       <= stb_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  sdp_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (we_s),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.d_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_q_s)
  );

  // The RAM output is undefined until read; mask it outside RD_OUT
  assign bus.stb_o = stb_q;
  assign bus.q_o   = stb_q ? ram_q_s : {DW{1'b0}};
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Self-checking bench for capture_ctrl: directed scenarios, a control-vector
// table and randomized captures against a memory/history reference model.
module tb_capture_ctrl;

  localparam int WIDTH = 4;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_stb;
  logic [15:0] cfg_read;
  logic [15:0] cfg_delay;
  logic        arm;
  logic        trg;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  capture_ctrl_if #(.WIDTH(WIDTH)) bus ();

  capture_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cfg_stb_i   (cfg_stb),
    .cfg_read_i  (cfg_read),
    .cfg_delay_i (cfg_delay),
    .arm_i       (arm),
    .trg_i       (trg),
    .bus         (bus),
    .busy_o      (busy),
    .done_o      (done)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: memory image, write pointer, capture phase, expected words
  int mem [DEPTH];
  bit vld [DEPTH];
  int wr;
  int phase;     // 0 idle, 1 armed, 2 post-trigger, 3 reading out
  int remain;
  int m_read;
  int m_delay;
  int exp_q [$]; // -1 marks a never-written location

  typedef struct {
    bit cs; int rd; int dl; bit ar; bit tr; bit st; int d;
    bit e_busy; bit e_stb;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic setup_read();
    int n;
    int idx;
    n = ((m_read > DEPTH - 1) ? DEPTH - 1 : m_read) + 1;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      idx = (wr - 1 - i + 2 * DEPTH) % DEPTH;
`ifdef CAPTURE_CTRL_NEWEST_FIRST_EN
      exp_q.push_back(vld[idx] ? mem[idx] : -1);
`else
      exp_q.push_front(vld[idx] ? mem[idx] : -1);
`endif
    end
    phase = 3;
  endtask

  task automatic wr_word(input int d);
    mem[wr] = d;
    vld[wr] = 1'b1;
    wr = (wr + 1) % DEPTH;
  endtask

  // One clock of stimulus; the model applies the same inputs at the same edge
  task automatic step(input bit cs, input int rd, input int dl, input bit ar,
                      input bit tr, input bit st, input int d, input bit rdy);
    cfg_stb   = cs;
    cfg_read  = 16'(rd);
    cfg_delay = 16'(dl);
    arm       = ar;
    trg       = tr;
    bus.stb_i = st;
    bus.d_i   = 32'(d);
    bus.rdy_i = rdy;
    case (phase)
      0: begin
        if (cs) begin
          m_read  = rd;
          m_delay = dl;
        end
        if (ar) phase = 1;
      end
      1: begin
        if (st) wr_word(d);
        if (tr) begin
          if (m_delay == 0) setup_read();
          else begin
            remain = m_delay;
            phase  = 2;
          end
        end
      end
      2: begin
        if (st) begin
          wr_word(d);
          remain--;
          if (remain == 0) setup_read();
        end
      end
      default: ;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic model_reset();
    phase = 0;
    wr = 0;
    m_read = 0;
    m_delay = 0;
    exp_q.delete();
  endtask

  // Drain up to 'limit' words; stall the transmitter on word 'stall_idx'
  task automatic readout(input int limit, input int stall_idx, input int stall_len);
    int k;
    int wait_n;
    k = 0;
    while (exp_q.size() > 0 && k < limit) begin
      wait_n = 0;
      while (!bus.stb_o && wait_n < 8) begin
        idle(1);
        wait_n++;
      end
      if (!bus.stb_o) begin
        chk("stb_timeout", 0, 1);
        exp_q.delete();
        phase = 0;
        return;
      end
      if (k == stall_idx) begin
        repeat (stall_len) begin
          idle(1);
          chk("stall_stb", bus.stb_o, 1);
          if (exp_q[0] >= 0) chk("stall_q", bus.q_o, exp_q[0]);
        end
      end
      if (exp_q[0] >= 0) chk($sformatf("word%0d", k), bus.q_o, exp_q[0]);
      void'(exp_q.pop_front());
      step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
      if (exp_q.size() == 0) begin
        chk("done_pulse", done, 1);
        chk("busy_end", busy, 0);
        chk("stb_end", bus.stb_o, 0);
        phase = 0;
        idle(1);
        chk("done_once", done, 0);
      end else begin
        chk("done_early", done, 0);
      end
      k++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int pre;
    int cnt;
    rst = 1'b1;
    cfg_stb = 1'b0; cfg_read = 16'd0; cfg_delay = 16'd0;
    arm = 1'b0; trg = 1'b0;
    bus.stb_i = 1'b0; bus.d_i = 32'd0; bus.rdy_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = 0;
      vld[i] = 1'b0;
    end
    model_reset();
    do_reset();
    chk("rst_stb", bus.stb_o, 0);
    chk("rst_q", bus.q_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    // Basic capture with backpressure on the second word; words 8..10 arrive during readout
    step(1'b1, 3, 2, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    step(1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    chk("arm_busy", busy, 1);
    for (int w = 1; w <= 10; w++) step(1'b0, 0, 0, 1'b0, (w == 5), 1'b1, w, 1'b0);
    readout(99, 1, 5);

    // Zero delay, single word
    step(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    step(1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    for (int w = 1; w <= 3; w++) step(1'b0, 0, 0, 1'b0, (w == 3), 1'b1, w, 1'b0);
    readout(99, -1, 0);

    // Wrap-around with a clamped read length
    step(1'b1, 40, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    step(1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    for (int w = 1; w <= 20; w++) step(1'b0, 0, 0, 1'b0, (w == 20), 1'b1, w, 1'b0);
    readout(99, 7, 2);

    // Ignored controls: trigger/data in IDLE, arm+trg, reconfigure and re-arm while capturing
    step(1'b1, 1, 1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    tbl[0] = '{1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 0,      1'b0, 1'b0};
    tbl[1] = '{1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 32'h5A, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 0,      1'b1, 1'b0};
    tbl[3] = '{1'b1, 5, 7, 1'b0, 1'b0, 1'b0, 0,      1'b1, 1'b0};
    tbl[4] = '{1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 0,      1'b1, 1'b0};
    tbl[5] = '{1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 32'hA1, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 32'hA2, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 0,      1'b1, 1'b0};
    tbl[8] = '{1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 32'hA3, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0,      1'b1, 1'b1};
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].cs, tbl[i].rd, tbl[i].dl, tbl[i].ar, tbl[i].tr, tbl[i].st, tbl[i].d, 1'b0);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("tbl%0d_stb", i), bus.stb_o, tbl[i].e_stb);
      chk($sformatf("tbl%0d_done", i), done, 0);
    end
    readout(99, -1, 0);

    // Reset after the second readout word, then a fresh capture
    step(1'b1, 5, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    step(1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    for (int w = 0; w < 16; w++) step(1'b0, 0, 0, 1'b0, (w == 15), 1'b1, 32'h100 + w, 1'b0);
    readout(2, -1, 0);
    rst = 1'b1;
    idle(1);
    chk("mid_rst_stb", bus.stb_o, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    rst = 1'b0;
    model_reset();
    step(1'b1, 2, 1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    step(1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    for (int w = 0; w < 5; w++) step(1'b0, 0, 0, 1'b0, (w == 3), 1'b1, 32'h200 + w, 1'b0);
    readout(99, 0, 1);

    // Randomized captures
    for (int it = 0; it < 10; it++) begin
      step(1'b1, $urandom_range(0, 20), $urandom_range(0, 4), 1'b0, 1'b0, 1'b0, 0, 1'b0);
      step(1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      pre = $urandom_range(0, 18);
      cnt = 0;
      while (phase != 3 && cnt < 80) begin
        step(1'b0, 0, 0, 1'b0,
             (cnt == pre) || (cnt > pre && $urandom_range(0, 3) == 0),
             ($urandom_range(0, 9) < 7), $urandom_range(0, 32'hFFFF), 1'b0);
        cnt++;
      end
      if (phase != 3) begin
        chk("capture_timeout", 0, 1);
        model_reset();
        do_reset();
      end else begin
        readout(99, $urandom_range(0, 3), $urandom_range(0, 3));
      end
      idle($urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
